// File: rtl/sram_controller.sv
// Data-memory responder for the MEM stage: one 32-bit load/store performed as
// two 16-bit accesses (low half first) on an external asynchronous SRAM.
module sram_controller #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int unsigned     CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wr;
  logic [15:0]        r_wdata_hi;
  logic [31:0]        r_read_data;
  logic [ADDR_W-1:0]  r_sram_addr;
  logic [15:0]        r_dq_out;
  logic               r_dq_oe;
  logic               r_we_n;
  logic               r_oe_n;

  logic [31:0]        w_offset;
  logic [31:0]        w_word;
  logic [ADDR_W-1:0]  w_lo_addr;
  logic               w_req;
  logic               w_cnt_last;

  // Byte address -> half-word SRAM address of the low half; truncation wraps silently.
  assign w_offset   = address - BASE_ADDR;
  assign w_word     = w_offset >> 2;
  assign w_lo_addr  = ADDR_W'({w_word, 1'b0});
  assign w_req      = wr_en | rd_en;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Combinational so the pipeline freezes in the same cycle a request appears.
  assign ready = (r_state == S_DONE) | ((r_state == S_IDLE) & ~wr_en & ~rd_en);

  assign read_data   = r_read_data;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_we_n   = r_we_n;
  assign sram_oe_n   = r_oe_n;

  // Access sequencer; SRAM strobes are registered and set on entry to each state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_wdata_hi  <= '0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state     <= S_LOW;
            r_cnt       <= '0;
            r_wr        <= wr_en;
            r_wdata_hi  <= write_data[31:16];
            r_sram_addr <= w_lo_addr;
            if (wr_en) begin
              r_dq_out <= write_data[15:0];
              r_dq_oe  <= 1'b1;
              r_we_n   <= 1'b0;
            end else begin
              r_oe_n   <= 1'b0;
            end
          end
        end

        S_LOW: begin
          if (w_cnt_last) begin
            if (!r_wr) begin
              r_read_data[15:0] <= sram_dq_in;
            end else begin
              r_dq_out <= r_wdata_hi;
            end
            r_state     <= S_HIGH;
            r_cnt       <= '0;
            r_sram_addr <= r_sram_addr | ADDR_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_HIGH: begin
          if (w_cnt_last) begin
            if (!r_wr) begin
              r_read_data[31:16] <= sram_dq_in;
            end
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_dq_oe <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: W=2 instance for the main scenarios,
// W=1 instance for address wrap; per-cycle expectations kept in a scoreboard queue.
module tb_sram_controller;

  typedef struct packed {
    logic [37:0] v;
    logic [37:0] m;
  } exp_t;

  logic clk;
  logic rst;

  logic        wr_en0, rd_en0;
  logic [31:0] address0, write_data0, read_data0;
  logic        ready0, dq_oe0, we_n0, oe_n0;
  logic [17:0] addr0;
  logic [15:0] dout0, dq_in0;

  logic        wr_en1, rd_en1;
  logic [31:0] address1, write_data1, read_data1;
  logic        ready1, dq_oe1, we_n1, oe_n1;
  logic [17:0] addr1;
  logic [15:0] dout1, dq_in1;

  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];

  logic [37:0] obs0, obs1;
  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] model_rd0, model_rd1;

  int n_checks = 0;
  int n_fail   = 0;

  sram_controller #(.ADDR_W(18), .WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(address0),
    .write_data(write_data0), .read_data(read_data0), .ready(ready0),
    .sram_addr(addr0), .sram_dq_out(dout0), .sram_dq_oe(dq_oe0),
    .sram_dq_in(dq_in0), .sram_we_n(we_n0), .sram_oe_n(oe_n0)
  );

  sram_controller #(.ADDR_W(18), .WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
    .write_data(write_data1), .read_data(read_data1), .ready(ready1),
    .sram_addr(addr1), .sram_dq_out(dout1), .sram_dq_oe(dq_oe1),
    .sram_dq_in(dq_in1), .sram_we_n(we_n1), .sram_oe_n(oe_n1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small SRAM models: combinational read, write sampled while the strobe is low.
  assign dq_in0 = mem0[addr0[3:0]];
  assign dq_in1 = mem1[addr1[3:0]];
  always @(posedge clk) if (!we_n0) mem0[addr0[3:0]] <= dout0;
  always @(posedge clk) if (!we_n1) mem1[addr1[3:0]] <= dout1;

  assign obs0 = {ready0, we_n0, oe_n0, dq_oe0, addr0, dout0};
  assign obs1 = {ready1, we_n1, oe_n1, dq_oe1, addr1, dout1};

  // Expected per-cycle {ready, we_n, oe_n, dq_oe, addr, dout} for one access of 2w+2 cycles.
  function automatic void push_access(bit wr, logic [17:0] h, logic [31:0] d, int w);
    exp_t        e;
    logic        hi;
    logic [37:0] full    = '1;
    logic [37:0] ctl     = {4'hF, 34'h0};
    logic [37:0] no_dout = {4'hF, 18'h3FFFF, 16'h0};
    e.v = {4'b0110, 34'h0};
    e.m = ctl;
    exp_q.push_back(e);
    for (int c = 1; c <= 2 * w; c++) begin
      hi  = (c > w);
      e.v = {1'b0, ~wr, wr, wr, h | {17'b0, hi}, hi ? d[31:16] : d[15:0]};
      e.m = wr ? full : no_dout;
      exp_q.push_back(e);
    end
    e.v = {4'b1110, h | 18'd1, d[31:16]};
    e.m = wr ? full : no_dout;
    exp_q.push_back(e);
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs0 !== {4'b1110, 34'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs0: got %h expected %h", obs0, {4'b1110, 34'h0});
    end
    n_checks++;
    if (obs1 !== {4'b1110, 34'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs1: got %h expected %h", obs1, {4'b1110, 34'h0});
    end
    n_checks++;
    if (read_data0 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_read_data: got %h expected 00000000", read_data0);
    end
    rd_en0 = 1'b1;
    #1;
    n_checks++;
    if (ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_req: got %b expected 0", ready0);
    end
    rd_en0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store();
    exp_t e;
    logic [31:0] rexp;
    wr_en0 = 1'b1; rd_en0 = 1'b0; address0 = 32'd1028; write_data0 = 32'hDEADBEEF;
    push_access(1'b1, 18'd2, 32'hDEADBEEF, 2);
    rd_q.push_back(model_rd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ((obs0 & e.m) !== (e.v & e.m)) begin
        n_fail++;
        $display("FAIL store cycle %0d: got %h expected %h", c, obs0 & e.m, e.v & e.m);
      end
      if (c == 5) begin
        rexp = rd_q.pop_front();
        n_checks++;
        if (read_data0 !== rexp) begin
          n_fail++;
          $display("FAIL store read_data: got %h expected %h", read_data0, rexp);
        end
      end
      @(posedge clk);
      #1;
    end
    wr_en0 = 1'b0;
    n_checks++;
    if ({mem0[3], mem0[2]} !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL store sram_contents: got %h expected deadbeef", {mem0[3], mem0[2]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load();
    exp_t e;
    logic [31:0] rexp;
    wr_en0 = 1'b0; rd_en0 = 1'b1; address0 = 32'd1028;
    push_access(1'b0, 18'd2, 32'h0, 2);
    model_rd0 = 32'hDEADBEEF;
    rd_q.push_back(model_rd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ((obs0 & e.m) !== (e.v & e.m)) begin
        n_fail++;
        $display("FAIL load cycle %0d: got %h expected %h", c, obs0 & e.m, e.v & e.m);
      end
      if (c == 5) begin
        rexp = rd_q.pop_front();
        n_checks++;
        if (read_data0 !== rexp) begin
          n_fail++;
          $display("FAIL load read_data: got %h expected %h", read_data0, rexp);
        end
      end
      @(posedge clk);
      #1;
      // Request withdrawn mid-access: the latched load must still complete.
      if (c == 1) begin
        rd_en0 = 1'b0; address0 = 32'h0;
      end
    end
    rd_en0 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_both();
    exp_t e;
    logic [31:0] rexp;
    wr_en0 = 1'b1; rd_en0 = 1'b1; address0 = 32'd1024; write_data0 = 32'h12345678;
    push_access(1'b1, 18'd0, 32'h12345678, 2);
    rd_q.push_back(model_rd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ((obs0 & e.m) !== (e.v & e.m)) begin
        n_fail++;
        $display("FAIL both cycle %0d: got %h expected %h", c, obs0 & e.m, e.v & e.m);
      end
      if (c == 5) begin
        rexp = rd_q.pop_front();
        n_checks++;
        if (read_data0 !== rexp) begin
          n_fail++;
          $display("FAIL both read_data: got %h expected %h", read_data0, rexp);
        end
      end
      @(posedge clk);
      #1;
    end
    wr_en0 = 1'b0; rd_en0 = 1'b0;
    n_checks++;
    if ({mem0[1], mem0[0]} !== 32'h12345678) begin
      n_fail++;
      $display("FAIL both sram_contents: got %h expected 12345678", {mem0[1], mem0[0]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] rexp;
    wr_en0 = 1'b1; rd_en0 = 1'b0; address0 = 32'd1032; write_data0 = 32'hCAFEF00D;
    push_access(1'b1, 18'd4, 32'hCAFEF00D, 2);
    rd_q.push_back(model_rd0);
    push_access(1'b0, 18'd4, 32'h0, 2);
    rd_q.push_back(32'hCAFEF00D);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ((obs0 & e.m) !== (e.v & e.m)) begin
        n_fail++;
        $display("FAIL b2b cycle %0d: got %h expected %h", c, obs0 & e.m, e.v & e.m);
      end
      if (c == 5 || c == 11) begin
        rexp = rd_q.pop_front();
        n_checks++;
        if (read_data0 !== rexp) begin
          n_fail++;
          $display("FAIL b2b read_data cycle %0d: got %h expected %h", c, read_data0, rexp);
        end
      end
      @(posedge clk);
      #1;
      // Load presented in the IDLE cycle right after the store's DONE.
      if (c == 5) begin
        wr_en0 = 1'b0; rd_en0 = 1'b1;
      end
    end
    model_rd0 = 32'hCAFEF00D;
    rd_en0 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    wr_en0 = 1'b1; rd_en0 = 1'b0; address0 = 32'd1040; write_data0 = 32'h11112222;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({we_n0, oe_n0, dq_oe0} !== 3'b110) begin
      n_fail++;
      $display("FAIL rstmid strobes: got %b expected 110", {we_n0, oe_n0, dq_oe0});
    end
    n_checks++;
    if (read_data0 !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid read_data: got %h expected 00000000", read_data0);
    end
    n_checks++;
    if (ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid ready_with_req: got %b expected 0", ready0);
    end
    wr_en0 = 1'b0;
    #1;
    n_checks++;
    if (ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid ready_no_req: got %b expected 1", ready0);
    end
    model_rd0 = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (obs0[37:34] !== 4'b1110) begin
      n_fail++;
      $display("FAIL rstmid idle_after_release: got %b expected 1110", obs0[37:34]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [31:0] rexp;
    wr_en1 = 1'b1; rd_en1 = 1'b0; address1 = 32'd1024; write_data1 = 32'h87654321;
    push_access(1'b1, 18'd0, 32'h87654321, 1);
    rd_q.push_back(model_rd1);
    push_access(1'b0, 18'd0, 32'h0, 1);
    rd_q.push_back(32'h87654321);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ((obs1 & e.m) !== (e.v & e.m)) begin
        n_fail++;
        $display("FAIL wrap cycle %0d: got %h expected %h", c, obs1 & e.m, e.v & e.m);
      end
      if (c == 3 || c == 7) begin
        rexp = rd_q.pop_front();
        n_checks++;
        if (read_data1 !== rexp) begin
          n_fail++;
          $display("FAIL wrap read_data cycle %0d: got %h expected %h", c, read_data1, rexp);
        end
      end
      @(posedge clk);
      #1;
      // Load from BASE_ADDR + 4*2^17, which truncates back to half-addresses 0/1.
      if (c == 3) begin
        wr_en1 = 1'b0; rd_en1 = 1'b1; address1 = 32'd1024 + 32'd524288;
      end
    end
    model_rd1 = 32'h87654321;
    rd_en1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    wr_en0 = 1'b0; rd_en0 = 1'b0; address0 = 32'h0; write_data0 = 32'h0;
    wr_en1 = 1'b0; rd_en1 = 1'b0; address1 = 32'h0; write_data1 = 32'h0;
    model_rd0 = 32'h0;
    model_rd1 = 32'h0;
    test_reset();
    test_store();
    test_load();
    test_both();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
